priority_select_pipe: RTL and testbench
=======================================

// Module: priority_select_pipe
// PURPOSE
//  Parametrised, pipelined successor of the nibble priority-select circuit.
//  Each input word splits into a selector field (upper SEL_W bits) and a data field (lower DATA_W bits).
//  Each word is classified ALL, ANY or NONE and reduced to a zero-extended result.
//  Results go through a DEPTH-entry output FIFO with valid/ready handshakes; per-class accept counters run alongside.
// PARAMETERS
//  SEL_W   4  selector field width (>=2)
//  DATA_W  4  data field width (>=3)
//  OUT_W   8  result width (>= DATA_W-2)
//  DEPTH   2  output FIFO entries (power of 2, >=2)
//  CNT_W   8  width of each class counter
// PORTS
//  clk        in   1               single clock, all logic on rising edge
//  clear      in   1               synchronous, active-low reset (clear==0 resets on clk edge)
//  in_valid   in   1               input word offered
//  in_ready   out  1               block can accept this cycle
//  cct_input  in   SEL_W+DATA_W    {sel, data}
//  out_valid  out  1               FIFO head valid
//  out_ready  in   1               consumer takes head this cycle
//  cct_output out  OUT_W           result at FIFO head
//  out_class  out  2               class of head entry (cls_e)
//  cnt_clr    in   1               synchronous clear of all class counters
//  cnt_all    out  CNT_W           accepted ALL-class words, saturating
//  cnt_any    out  CNT_W           accepted ANY-class words, saturating
//  cnt_none   out  CNT_W           accepted NONE-class words, saturating
// BEHAVIOUR
//  - Accept: in_valid && in_ready. Pop: out_valid && out_ready.
//  - Classification (combinational on accepted word), with sel = cct_input[SEL_W+DATA_W-1:DATA_W]:
//    - &sel            -> CLS_ALL,  result = zext(data[DATA_W-1])
//    - |sel, not &sel  -> CLS_ANY,  result = zext(data[DATA_W-2])
//    - sel == 0        -> CLS_NONE, result = zext(data[DATA_W-3:0])
//    - ALL takes priority over ANY. Zero-extend to OUT_W; never truncate.
//  - Latency: a word accepted in cycle N is at the FIFO head with out_valid=1 in cycle N+1 when the FIFO was empty.
//  - FIFO order is strict; no bypass path from cct_input to cct_output.
//  - in_ready = !full || out_ready. A simultaneous push and pop when full is legal; count stays DEPTH.
//  - Push and pop in the same cycle when empty: no pop occurs, because out_valid=0. The push lands.
//  - Pointers wrap modulo DEPTH. An occupancy counter of width $clog2(DEPTH)+1 distinguishes full from empty.
//  - cct_output and out_class hold their value while out_valid && !out_ready. When out_valid=0 they are don't-care; drive 0.
//  - Counters increment by 1 per accepted word of their class and saturate at 2^CNT_W-1 (no wrap).
//  - cnt_clr together with an accept: clear wins and that word is not counted.
//  - Reset (clear==0): FIFO emptied, pointers and occupancy 0, out_valid=0, cct_output=0, out_class=CLS_NONE, all counters 0.
//  - in_ready=0 during the reset cycle.
//  - Reset mid-stream discards all queued entries; nothing is popped that cycle.
//  - Reset overrides cnt_clr, accept and pop.
// STRUCTURE
//  - Package priority_select_pkg:
//    - typedef enum logic [1:0] cls_e {CLS_NONE=0, CLS_ANY=1, CLS_ALL=2}
//    - function classify(sel) -> cls_e
//  - Sub-module ps_fifo: parametrised synchronous FIFO (width OUT_W+2, DEPTH) with full/empty/count outputs.
//    Classification logic and counters stay in the top level.
// TESTING (defaults SEL_W=4, DATA_W=4, OUT_W=8, DEPTH=2)
//  1. cct_input=8'hF8 (ALL), then 8'h14 (ANY), then 8'h03 (NONE), out_ready=1 ->
//     outputs 8'h01/CLS_ALL, 8'h01/CLS_ANY, 8'h03/CLS_NONE, each 1 cycle after accept; cnt_all=cnt_any=cnt_none=1.
//  2. out_ready=0, push 3 words -> in_ready=0 after 2 accepts.
//     Then raise out_ready with in_valid=1 -> push and pop in the same cycle, order preserved.
//  3. CNT_W=2, 5 ALL words -> cnt_all sticks at 3.
//     cnt_clr asserted together with a 6th accept -> cnt_all=0.
//  4. FIFO full, drive clear=0 for one cycle -> next cycle out_valid=0, cct_output=0, counters 0.
//     First accept after release appears one cycle later.
//  5. Random in_valid/out_ready for 10k cycles against a scoreboard model -> no loss, no duplication.
//     Per-class counts match the model; pointer wrap exercised.

Source files
------------

// File: rtl/priority_select_pkg.sv
// Shared class encoding and selector classification for priority_select_pipe.
package priority_select_pkg;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ANY  = 2'd1,
    CLS_ALL  = 2'd2
  } cls_e;

  localparam int SEL_MAX_W = 32;

  // Callers zero-extend the selector to SEL_MAX_W and pass its real width.
  function automatic cls_e classify(input logic [SEL_MAX_W-1:0] sel, input int sel_w);
    logic [SEL_MAX_W-1:0] mask;
    mask = (sel_w >= SEL_MAX_W) ? '1 : ((SEL_MAX_W'(1) << sel_w) - SEL_MAX_W'(1));
    if ((sel & mask) == mask) return CLS_ALL;
    if ((sel & mask) != '0) return CLS_ANY;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/ps_fifo.sv
// Synchronous FIFO with occupancy counter; storage is not reset, control is.
module ps_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, a push may only land if the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/priority_select_pipe.sv
// Classifies {sel, data} words into ALL/ANY/NONE, queues results in an output
// FIFO and keeps saturating per-class accept counters.
module priority_select_pipe #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 4,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W+DATA_W-1:0] cct_input,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        cct_output,
  output logic [1:0]              out_class,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        cnt_all,
  output logic [CNT_W-1:0]        cnt_any,
  output logic [CNT_W-1:0]        cnt_none
);
  import priority_select_pkg::*;

  localparam int IN_W = SEL_W + DATA_W;
  localparam int FW   = OUT_W + 2;
  localparam int CW   = $clog2(DEPTH) + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SEL_W-1:0]  sel_p0;
  logic [DATA_W-1:0] data_p0;
  cls_e              cls_p0;
  logic [OUT_W-1:0]  res_p0;
  logic              vld_p0;
  logic [FW-1:0]     rdata;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;

  // Stage p0: classify the offered word combinationally.
  assign sel_p0  = cct_input[IN_W-1:DATA_W];
  assign data_p0 = cct_input[DATA_W-1:0];
  assign cls_p0  = classify(SEL_MAX_W'(sel_p0), SEL_W);

  always_comb begin
    res_p0 = '0;
    case (cls_p0)
      CLS_ALL: res_p0 = OUT_W'(data_p0[DATA_W-1]);
      CLS_ANY: res_p0 = OUT_W'(data_p0[DATA_W-2]);
      default: res_p0 = OUT_W'(data_p0[DATA_W-3:0]);
    endcase
  end

  assign in_ready = clear & (~full | out_ready);
  assign vld_p0   = in_valid & in_ready;

  ps_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (vld_p0),
    .pop   (out_valid & out_ready),
    .wdata ({cls_p0, res_p0}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Stage p1: FIFO head; outputs forced to zero while nothing is queued.
  assign out_valid  = (count != '0);
  assign cct_output = empty ? '0 : rdata[OUT_W-1:0];
  assign out_class  = empty ? CLS_NONE : rdata[FW-1:OUT_W];

  always_ff @(posedge clk) begin
    if (!clear || cnt_clr) begin
      cnt_all  <= '0;
      cnt_any  <= '0;
      cnt_none <= '0;
    end else if (vld_p0) begin
      case (cls_p0)
        CLS_ALL: cnt_all  <= sat_inc(cnt_all);
        CLS_ANY: cnt_any  <= sat_inc(cnt_any);
        default: cnt_none <= sat_inc(cnt_none);
      endcase
    end
  end

endmodule

// File: tb/tb_priority_select_pipe.sv
// Bench for priority_select_pipe: directed vectors plus random traffic vs a queue model.
module tb_priority_select_pipe;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cct_input = 8'h00;
  logic       in_ready, out_valid, s_in_ready, s_out_valid;
  logic [7:0] cct_output, s_cct_output, cnt_all, cnt_any, cnt_none;
  logic [1:0] out_class, s_out_class, s_cnt_all, s_cnt_any, s_cnt_none;

  priority_select_pipe dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .cct_input(cct_input), .out_valid(out_valid), .out_ready(out_ready),
    .cct_output(cct_output), .out_class(out_class), .cnt_clr(cnt_clr),
    .cnt_all(cnt_all), .cnt_any(cnt_any), .cnt_none(cnt_none)
  );

  priority_select_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .cct_input(cct_input), .out_valid(s_out_valid), .out_ready(out_ready),
    .cct_output(s_cct_output), .out_class(s_out_class), .cnt_clr(cnt_clr),
    .cnt_all(s_cnt_all), .cnt_any(s_cnt_any), .cnt_none(s_cnt_none)
  );

  typedef struct {int res; int cls;} ent_t;
  typedef struct {logic [7:0] vin; int res; int cls;} vec_t;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  ent_t q[$];
  int   m_all = 0, m_any = 0, m_none = 0;
  int   s_all = 0, s_any = 0, s_none = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference classification from the selector/data rules.
  function automatic ent_t model_word(input logic [7:0] w);
    ent_t e;
    int sel = int'(w) / 16;
    int d   = int'(w) % 16;
    if (sel == 15) begin
      e.cls = 2; e.res = (d / 8) % 2;
    end else if (sel != 0) begin
      e.cls = 1; e.res = (d / 4) % 2;
    end else begin
      e.cls = 0; e.res = d % 4;
    end
    return e;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic compare();
    int ev = (q.size() > 0) ? 1 : 0;
    int er = 0;
    int ec = 0;
    if (ev == 1) begin
      er = q[0].res; ec = q[0].cls;
    end
    check("out_valid", int'(out_valid), ev);
    check("in_ready", int'(in_ready), int'(clear && (q.size() < DEPTH || out_ready)));
    check("cct_output", int'(cct_output), er);
    check("out_class", int'(out_class), ec);
    check("cnt_all", int'(cnt_all), m_all);
    check("cnt_any", int'(cnt_any), m_any);
    check("cnt_none", int'(cnt_none), m_none);
    check("sat_out_valid", int'(s_out_valid), ev);
    check("sat_cct_output", int'(s_cct_output), er);
    check("sat_cnt_all", int'(s_cnt_all), s_all);
    check("sat_cnt_any", int'(s_cnt_any), s_any);
    check("sat_cnt_none", int'(s_cnt_none), s_none);
  endtask

  // Check outputs mid-cycle, then advance the model across one rising edge.
  task automatic tick();
    bit   rst, acc, pop, clr;
    ent_t e;
    #1;
    compare();
    rst = !clear;
    clr = cnt_clr;
    acc = clear && in_valid && (q.size() < DEPTH || out_ready);
    pop = clear && (q.size() > 0) && out_ready;
    e   = model_word(cct_input);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_all = 0; m_any = 0; m_none = 0; s_all = 0; s_any = 0; s_none = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc) q.push_back(e);
      if (clr) begin
        m_all = 0; m_any = 0; m_none = 0; s_all = 0; s_any = 0; s_none = 0;
      end else if (acc) begin
        case (e.cls)
          2:       begin m_all  = sat(m_all, 255);  s_all  = sat(s_all, 3);  end
          1:       begin m_any  = sat(m_any, 255);  s_any  = sat(s_any, 3);  end
          default: begin m_none = sat(m_none, 255); s_none = sat(s_none, 3); end
        endcase
      end
    end
    #1;
  endtask

  initial begin
    vec_t tbl[10];
    int   n_all, n_any, n_none;
    logic [3:0] rsel;
    int   r;

    tbl[0] = '{8'hF8, 1, 2};
    tbl[1] = '{8'h14, 1, 1};
    tbl[2] = '{8'h03, 3, 0};
    tbl[3] = '{8'hF0, 0, 2};
    tbl[4] = '{8'h80, 0, 1};
    tbl[5] = '{8'h0F, 3, 0};
    tbl[6] = '{8'h7C, 1, 1};
    tbl[7] = '{8'hFF, 1, 2};
    tbl[8] = '{8'h00, 0, 0};
    tbl[9] = '{8'hE4, 1, 1};

    // Reset state
    clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_cct_output", int'(cct_output), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_cnt_all", int'(cnt_all), 0);
    in_valid = 1'b0;
    tick();

    // Table vectors: continuous stream, each result at the head one cycle after accept
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cct_input = tbl[i].vin;
      tick();
      check("tbl_valid", int'(out_valid), 1);
      check("tbl_res", int'(cct_output), tbl[i].res);
      check("tbl_cls", int'(out_class), tbl[i].cls);
      if (i == 2) begin
        check("t1_cnt_all", int'(cnt_all), 1);
        check("t1_cnt_any", int'(cnt_any), 1);
        check("t1_cnt_none", int'(cnt_none), 1);
      end
    end
    in_valid = 1'b0;
    tick();
    n_all = 0; n_any = 0; n_none = 0;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].cls == 2) n_all++;
      else if (tbl[i].cls == 1) n_any++;
      else n_none++;
    end
    check("tbl_cnt_all", int'(cnt_all), n_all);
    check("tbl_cnt_any", int'(cnt_any), n_any);
    check("tbl_cnt_none", int'(cnt_none), n_none);

    // Backpressure: fill, stall, then push and pop in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    cct_input = 8'hF8; tick();
    cct_input = 8'h14; tick();
    cct_input = 8'h03; #1;
    check("full_in_ready", int'(in_ready), 0);
    tick();
    out_ready = 1'b1; #1;
    check("full_pushpop_ready", int'(in_ready), 1);
    tick();
    check("order_res1", int'(cct_output), 1);
    check("order_cls1", int'(out_class), 1);
    in_valid = 1'b0;
    tick();
    check("order_res2", int'(cct_output), 3);
    check("order_cls2", int'(out_class), 0);
    tick();
    check("drained", int'(out_valid), 0);

    // Saturation on the CNT_W=2 instance; clear beats a simultaneous accept
    clear = 1'b0; tick(); clear = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; cct_input = 8'hF8;
    repeat (5) tick();
    check("sat_stick", int'(s_cnt_all), 3);
    check("nosat_all", int'(cnt_all), 5);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_wins_sat", int'(s_cnt_all), 0);
    check("clr_wins", int'(cnt_all), 0);
    in_valid = 1'b0; tick();

    // Reset while full discards the queue
    out_ready = 1'b0; in_valid = 1'b1;
    cct_input = 8'h14; tick();
    cct_input = 8'hFF; tick();
    clear = 1'b0; #1;
    check("rst_full_in_ready", int'(in_ready), 0);
    tick();
    clear = 1'b1; in_valid = 1'b0;
    check("rst_full_valid", int'(out_valid), 0);
    check("rst_full_out", int'(cct_output), 0);
    check("rst_full_cls", int'(out_class), 0);
    check("rst_full_any", int'(cnt_any), 0);
    check("rst_full_all", int'(cnt_all), 0);
    in_valid = 1'b1; cct_input = 8'h0F; tick(); in_valid = 1'b0;
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_out", int'(cct_output), 3);

    // Random traffic
    pops = 0;
    for (int c = 0; c < 10000; c++) begin
      r = int'($urandom_range(0, 3));
      rsel = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(1, 14));
      cct_input = {rsel, 4'($urandom_range(0, 15))};
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cnt_clr   = ($urandom_range(0, 2999) == 0);
      clear     = ($urandom_range(0, 3999) != 0);
      tick();
    end
    clear = 1'b1; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rand_pops_seen", int'(pops > 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
